// File: rtl/tile_ni_if.sv
// Bundles the PE-side packet ports and the router-side byte ports of one tile NI.
interface tile_ni_if #(
    parameter int unsigned PAYLOAD_BYTES = 4
);
    localparam int unsigned PW = 8 * PAYLOAD_BYTES;

    logic          tx_valid;
    logic          tx_ready;
    logic [3:0]    tx_dst_x;
    logic [3:0]    tx_dst_y;
    logic [PW-1:0] tx_payload;
    logic [7:0]    out_byte;
    logic          out_valid;
    logic          out_ready;
    logic [7:0]    in_byte;
    logic          in_valid;
    logic          in_ready;
    logic          rx_valid;
    logic          rx_ready;
    logic [PW-1:0] rx_payload;
    logic [7:0]    rx_src_hdr;
    logic [7:0]    drop_count;

    // NI side
    modport slave (
        input  tx_valid, tx_dst_x, tx_dst_y, tx_payload, out_ready, in_byte, in_valid, rx_ready,
        output tx_ready, out_byte, out_valid, in_ready, rx_valid, rx_payload, rx_src_hdr,
        drop_count
    );

    // PE / router side
    modport master (
        output tx_valid, tx_dst_x, tx_dst_y, tx_payload, out_ready, in_byte, in_valid, rx_ready,
        input  tx_ready, out_byte, out_valid, in_ready, rx_valid, rx_payload, rx_src_hdr,
        drop_count
    );
endinterface

// File: rtl/tile_ni.sv
// Tile network interface: serialises PE packets into header+payload byte frames towards the
// router, and deserialises incoming frames into an ejection FIFO, dropping misrouted ones.
module tile_ni #(
    parameter int unsigned X_COORD       = 0,
    parameter int unsigned Y_COORD       = 0,
    parameter int unsigned PAYLOAD_BYTES = 4,
    parameter int unsigned FIFO_DEPTH    = 4
) (
    input logic    clk,
    input logic    rst,
    tile_ni_if.slave bus
);
    localparam int unsigned PW  = 8 * PAYLOAD_BYTES;
    localparam int unsigned EW  = PW + 8;
    localparam int unsigned AW  = $clog2(FIFO_DEPTH);
    localparam int unsigned ONE = 1;
    localparam int unsigned LRX = PAYLOAD_BYTES - 1;

    localparam logic [0:0] T_IDLE = 1'b0;
    localparam logic [0:0] T_SEND = 1'b1;
    localparam logic [0:0] R_HDR  = 1'b0;
    localparam logic [0:0] R_BODY = 1'b1;

    localparam logic [4:0]    LAST_TX  = PAYLOAD_BYTES[4:0];
    localparam logic [4:0]    LAST_RX  = LRX[4:0];
    localparam logic [4:0]    CNT_ONE  = ONE[4:0];
    localparam logic [7:0]    MY_ADDR  = {X_COORD[3:0], Y_COORD[3:0]};
    localparam logic [AW:0]   DEPTH_C  = FIFO_DEPTH[AW:0];
    localparam logic [AW:0]   OCC_ONE  = ONE[AW:0];
    localparam logic [AW-1:0] PTR_ONE  = ONE[AW-1:0];

    // TX state
    logic [0:0]    tx_state_q, tx_state_d;
    logic [4:0]    tx_cnt_q, tx_cnt_d;
    logic [PW-1:0] tx_shift_q, tx_shift_d;
    logic [7:0]    out_byte_q, out_byte_d;
    logic          out_valid_q, out_valid_d;

    // RX state
    logic [0:0]    rx_state_q, rx_state_d;
    logic [4:0]    rx_cnt_q, rx_cnt_d;
    logic [7:0]    hdr_q, hdr_d;
    logic          match_q, match_d;
    logic [PW-1:0] asm_q, asm_d;
    logic [7:0]    drop_q, drop_d;

    // Ejection FIFO
    logic [EW-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   occ_q;

    logic          tx_ready, in_ready, tx_fire, in_fire, push, pop, full;
    logic [PW+7:0] asm_cat;
    logic [EW-1:0] head;

    // Ready signals are forced low while reset is held.
    assign tx_ready = (tx_state_q == T_IDLE) && !rst;
    assign full     = (occ_q == DEPTH_C);
    assign in_ready = !full && !rst;
    assign tx_fire  = bus.tx_valid && tx_ready;
    assign in_fire  = bus.in_valid && in_ready;
    assign asm_cat  = {asm_q, bus.in_byte};
    assign pop      = (occ_q != '0) && bus.rx_ready;
    assign head     = mem_q[rd_ptr_q];

    // TX serialiser: header first, then payload MSB first.
    always_comb begin
        tx_state_d  = tx_state_q;
        tx_cnt_d    = tx_cnt_q;
        tx_shift_d  = tx_shift_q;
        out_byte_d  = out_byte_q;
        out_valid_d = out_valid_q;
        if (tx_state_q == T_IDLE) begin
            if (tx_fire) begin
                tx_shift_d  = bus.tx_payload;
                out_byte_d  = {bus.tx_dst_x, bus.tx_dst_y};
                out_valid_d = 1'b1;
                tx_cnt_d    = '0;
                tx_state_d  = T_SEND;
            end
        end else if (bus.out_ready) begin
            if (tx_cnt_q == LAST_TX) begin
                out_valid_d = 1'b0;
                tx_state_d  = T_IDLE;
            end else begin
                out_byte_d = tx_shift_q[PW-1 -: 8];
                tx_shift_d = tx_shift_q << 8;
                tx_cnt_d   = tx_cnt_q + CNT_ONE;
            end
        end
    end

    // RX deserialiser: latch header, assemble payload, push or drop on the last byte.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        hdr_d      = hdr_q;
        match_d    = match_q;
        asm_d      = asm_q;
        drop_d     = drop_q;
        push       = 1'b0;
        if (in_fire) begin
            if (rx_state_q == R_HDR) begin
                hdr_d      = bus.in_byte;
                match_d    = (bus.in_byte == MY_ADDR);
                rx_cnt_d   = '0;
                rx_state_d = R_BODY;
            end else begin
                asm_d    = asm_cat[PW-1:0];
                rx_cnt_d = rx_cnt_q + CNT_ONE;
                if (rx_cnt_q == LAST_RX) begin
                    rx_state_d = R_HDR;
                    if (match_q) begin
                        push = 1'b1;
                    end else if (drop_q != 8'hFF) begin
                        drop_d = drop_q + 8'd1;
                    end
                end
            end
        end
    end

    // State registers for both FSMs and the FIFO, all cleared on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q  <= T_IDLE;
            tx_cnt_q    <= '0;
            tx_shift_q  <= '0;
            out_byte_q  <= '0;
            out_valid_q <= 1'b0;
            rx_state_q  <= R_HDR;
            rx_cnt_q    <= '0;
            hdr_q       <= '0;
            match_q     <= 1'b0;
            asm_q       <= '0;
            drop_q      <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            occ_q       <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            tx_state_q  <= tx_state_d;
            tx_cnt_q    <= tx_cnt_d;
            tx_shift_q  <= tx_shift_d;
            out_byte_q  <= out_byte_d;
            out_valid_q <= out_valid_d;
            rx_state_q  <= rx_state_d;
            rx_cnt_q    <= rx_cnt_d;
            hdr_q       <= hdr_d;
            match_q     <= match_d;
            asm_q       <= asm_d;
            drop_q      <= drop_d;
            if (push) begin
                mem_q[wr_ptr_q] <= {hdr_q, asm_cat[PW-1:0]};
                wr_ptr_q        <= wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            if (push && !pop) begin
                occ_q <= occ_q + OCC_ONE;
            end else if (pop && !push) begin
                occ_q <= occ_q - OCC_ONE;
            end
        end
    end

    assign bus.tx_ready   = tx_ready;
    assign bus.out_byte   = out_byte_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.in_ready   = in_ready;
    assign bus.rx_valid   = (occ_q != '0);
    assign bus.rx_payload = head[PW-1:0];
    assign bus.rx_src_hdr = head[EW-1:PW];
    assign bus.drop_count = drop_q;
endmodule

// File: tb/tb_tile_ni.sv
// Directed bench for tile_ni at tile (1,2), 4-byte payload, 4-entry ejection FIFO.
module tb_tile_ni;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    tile_ni_if #(.PAYLOAD_BYTES(4)) bus ();

    tile_ni #(
        .X_COORD(1),
        .Y_COORD(2),
        .PAYLOAD_BYTES(4),
        .FIFO_DEPTH(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Offer one byte and wait (bounded) until it is accepted.
    task automatic send_byte(input logic [7:0] b);
        int   n;
        logic acc;
        bus.in_byte  = b;
        bus.in_valid = 1'b1;
        n = 0;
        do begin
            acc = bus.in_ready;
            tick();
            n++;
        end while (!acc && n < 50);
        bus.in_valid = 1'b0;
        chk("in_accept", {31'd0, acc}, 32'd1);
    endtask

    task automatic send_frame(input logic [7:0] hdr, input logic [31:0] p);
        send_byte(hdr);
        for (int i = 3; i >= 0; i--) send_byte(p[8*i +: 8]);
    endtask

    task automatic pop();
        bus.rx_ready = 1'b1;
        tick();
        bus.rx_ready = 1'b0;
    endtask

    function automatic logic [31:0] pay(input int k);
        logic [7:0] b;
        b = k[7:0];
        return {8'h10 + b, 8'h20 + b, 8'h30 + b, 8'h40 + b};
    endfunction

    logic [7:0]  exp_b [5];
    logic [7:0]  got_b [5];
    logic [0:15] pat;
    int          got, stable_err, rdy_err;
    logic        prev_stall;
    logic [7:0]  prev_b;

    initial begin
        bus.tx_valid   = 1'b0;
        bus.tx_dst_x   = '0;
        bus.tx_dst_y   = '0;
        bus.tx_payload = '0;
        bus.out_ready  = 1'b0;
        bus.in_byte    = '0;
        bus.in_valid   = 1'b0;
        bus.rx_ready   = 1'b0;

        // Reset values while rst is held
        repeat (3) tick();
        chk("rst_tx_ready", {31'd0, bus.tx_ready}, 32'd0);
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_out_byte", {24'd0, bus.out_byte}, 32'd0);
        chk("rst_rx_valid", {31'd0, bus.rx_valid}, 32'd0);
        chk("rst_drop", {24'd0, bus.drop_count}, 32'd0);
        rst = 1'b0;
        tick();
        chk("idle_tx_ready", {31'd0, bus.tx_ready}, 32'd1);
        chk("idle_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("idle_rx_valid", {31'd0, bus.rx_valid}, 32'd0);
        chk("idle_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("idle_drop", {24'd0, bus.drop_count}, 32'd0);

        // Inject (2,3) 0xDEADBEEF with out_ready held high
        exp_b[0] = 8'h23; exp_b[1] = 8'hDE; exp_b[2] = 8'hAD; exp_b[3] = 8'hBE; exp_b[4] = 8'hEF;
        bus.tx_dst_x = 4'd2; bus.tx_dst_y = 4'd3; bus.tx_payload = 32'hDEADBEEF;
        bus.tx_valid = 1'b1; bus.out_ready = 1'b1;
        tick();
        bus.tx_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("tx_out_valid", {31'd0, bus.out_valid}, 32'd1);
            chk("tx_byte", {24'd0, bus.out_byte}, {24'd0, exp_b[i]});
            chk("tx_ready_busy", {31'd0, bus.tx_ready}, 32'd0);
            tick();
        end
        chk("tx_done_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("tx_done_ready", {31'd0, bus.tx_ready}, 32'd1);

        // Same frame with out_ready toggling
        pat = 16'b1001011001101111;
        bus.out_ready = 1'b0;
        bus.tx_valid = 1'b1;
        tick();
        bus.tx_valid = 1'b0;
        got = 0; stable_err = 0; rdy_err = 0; prev_stall = 1'b0; prev_b = '0;
        for (int k = 0; k < 16 && got < 5; k++) begin
            if (prev_stall && bus.out_byte !== prev_b) stable_err++;
            if (bus.out_valid && bus.tx_ready) rdy_err++;
            bus.out_ready = pat[k];
            if (bus.out_valid && pat[k]) begin
                got_b[got] = bus.out_byte;
                got++;
            end
            prev_stall = bus.out_valid && !pat[k];
            prev_b = bus.out_byte;
            tick();
        end
        bus.out_ready = 1'b0;
        chk("stall_count", got, 32'd5);
        for (int i = 0; i < 5; i++) chk("stall_byte", {24'd0, got_b[i]}, {24'd0, exp_b[i]});
        chk("stall_stable", stable_err, 32'd0);
        chk("stall_tx_ready", rdy_err, 32'd0);
        chk("stall_done_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("stall_done_ready", {31'd0, bus.tx_ready}, 32'd1);

        // Receive a matching frame, then a misrouted one
        send_byte(8'h12); send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
        chk("rx_not_yet", {31'd0, bus.rx_valid}, 32'd0);
        send_byte(8'h04);
        chk("rx_valid", {31'd0, bus.rx_valid}, 32'd1);
        chk("rx_payload", bus.rx_payload, 32'h01020304);
        chk("rx_hdr", {24'd0, bus.rx_src_hdr}, 32'h12);
        pop();
        chk("rx_popped", {31'd0, bus.rx_valid}, 32'd0);
        send_frame(8'h13, 32'h55667788);
        chk("drop_no_valid", {31'd0, bus.rx_valid}, 32'd0);
        chk("drop_count", {24'd0, bus.drop_count}, 32'd1);

        // Fill the FIFO, stall the 5th header, pop to release it
        for (int k = 0; k < 4; k++) send_frame(8'h12, pay(k));
        chk("full_in_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("full_rx_valid", {31'd0, bus.rx_valid}, 32'd1);
        bus.in_byte = 8'h12; bus.in_valid = 1'b1;
        repeat (3) tick();
        chk("stall_hdr_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("full_head", bus.rx_payload, pay(0));
        pop();
        chk("resume_in_ready", {31'd0, bus.in_ready}, 32'd1);
        send_frame(8'h12, pay(4));
        for (int k = 1; k < 5; k++) begin
            chk("order_valid", {31'd0, bus.rx_valid}, 32'd1);
            chk("order_payload", bus.rx_payload, pay(k));
            chk("order_hdr", {24'd0, bus.rx_src_hdr}, 32'h12);
            pop();
        end
        chk("order_empty", {31'd0, bus.rx_valid}, 32'd0);

        // Reset mid-frame on both paths
        send_byte(8'h12); send_byte(8'hAA); send_byte(8'hBB);
        bus.tx_dst_x = 4'd1; bus.tx_dst_y = 4'd2; bus.tx_payload = 32'hCAFEF00D;
        bus.tx_valid = 1'b1; bus.out_ready = 1'b1;
        tick();
        bus.tx_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1; bus.out_ready = 1'b0;
        tick();
        chk("mrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("mrst_out_byte", {24'd0, bus.out_byte}, 32'd0);
        chk("mrst_tx_ready", {31'd0, bus.tx_ready}, 32'd0);
        chk("mrst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("mrst_rx_valid", {31'd0, bus.rx_valid}, 32'd0);
        chk("mrst_rx_payload", bus.rx_payload, 32'd0);
        chk("mrst_rx_hdr", {24'd0, bus.rx_src_hdr}, 32'd0);
        chk("mrst_drop", {24'd0, bus.drop_count}, 32'd0);
        rst = 1'b0;
        tick();
        send_frame(8'h12, 32'h05060708);
        chk("post_rx_valid", {31'd0, bus.rx_valid}, 32'd1);
        chk("post_rx_payload", bus.rx_payload, 32'h05060708);
        chk("post_rx_hdr", {24'd0, bus.rx_src_hdr}, 32'h12);
        pop();
        exp_b[0] = 8'h34; exp_b[1] = 8'h11; exp_b[2] = 8'h22; exp_b[3] = 8'h33; exp_b[4] = 8'h44;
        bus.tx_dst_x = 4'd3; bus.tx_dst_y = 4'd4; bus.tx_payload = 32'h11223344;
        bus.tx_valid = 1'b1; bus.out_ready = 1'b1;
        tick();
        bus.tx_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("post_tx_byte", {24'd0, bus.out_byte}, {24'd0, exp_b[i]});
            tick();
        end
        chk("post_tx_done", {31'd0, bus.out_valid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
